// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clk_meas frequency/period meter.
package clk_meas_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    localparam int SYNC_STAGES = 3;
    localparam int FACTOR_W    = 5;

endpackage

// File: rtl/clk_meas_edge_sync.sv
// Synchronizes an asynchronous slow clock into the fsys domain and flags its rising edges.
module edge_sync
    import clk_meas_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // Edge taken between the last two stages so the first stage only resolves metastability.
    assign rise = sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];

endmodule

// File: rtl/clk_meas.sv
// Counts fsys cycles between rising edges of clk_meas_in, decodes power-of-two periods
// and reports lock when two consecutive periods match.
module clk_meas
    import clk_meas_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_meas_fsys,
    input  logic                 clk_meas_rst,
    input  logic                 clk_meas_in,
    output logic [CNT_WIDTH-1:0] clk_meas_period,
    output logic [FACTOR_W-1:0]  clk_meas_factor,
    output logic                 clk_meas_pow2,
    output logic                 clk_meas_valid,
    output logic                 clk_meas_locked,
    output logic                 clk_meas_timeout
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 rise;
    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] counter, counter_n;
    logic [CNT_WIDTH-1:0] prev, prev_n;
    logic [CNT_WIDTH-1:0] period_n;
    logic [FACTOR_W-1:0]  factor_n, dec_factor;
    logic                 pow2_n, dec_pow2, onehot;
    logic                 valid_n, locked_n, timeout_n;

    edge_sync u_sync (
        .clk  (clk_meas_fsys),
        .rst  (clk_meas_rst),
        .din  (clk_meas_in),
        .rise (rise)
    );

    // Bit 0 (period 1) and bits above 31 cannot be expressed as a factor, so they decode as 0.
    always_comb begin
        dec_pow2   = 1'b0;
        dec_factor = '0;
        onehot     = (counter != '0) && ((counter & (counter - CNT_ONE)) == '0);
        for (int i = 1; i < CNT_WIDTH && i < 32; i++) begin
            if (onehot && counter[i]) begin
                dec_pow2   = 1'b1;
                dec_factor = FACTOR_W'(i);
            end
        end
    end

    always_comb begin
        state_n   = state;
        counter_n = counter;
        prev_n    = prev;
        period_n  = clk_meas_period;
        factor_n  = clk_meas_factor;
        pow2_n    = clk_meas_pow2;
        locked_n  = clk_meas_locked;
        valid_n   = 1'b0;
        timeout_n = 1'b0;
        case (state)
            ST_IDLE: begin
                counter_n = '0;
                if (rise) begin
                    counter_n = CNT_ONE;
                    state_n   = ST_MEAS;
                end
            end
            ST_MEAS: begin
                // A rise on the saturated count is still a valid measurement.
                if (rise) begin
                    period_n  = counter;
                    factor_n  = dec_factor;
                    pow2_n    = dec_pow2;
                    valid_n   = 1'b1;
                    locked_n  = (counter == prev);
                    prev_n    = counter;
                    counter_n = CNT_ONE;
                end else if (counter == CNT_MAX) begin
                    timeout_n = 1'b1;
                    state_n   = ST_IDLE;
                    locked_n  = 1'b0;
                    prev_n    = '0;
                    counter_n = '0;
                end else begin
                    counter_n = counter + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_meas_fsys or posedge clk_meas_rst) begin
        if (clk_meas_rst) begin
            state            <= ST_IDLE;
            counter          <= '0;
            prev             <= '0;
            clk_meas_period  <= '0;
            clk_meas_factor  <= '0;
            clk_meas_pow2    <= 1'b0;
            clk_meas_valid   <= 1'b0;
            clk_meas_locked  <= 1'b0;
            clk_meas_timeout <= 1'b0;
        end else begin
            state            <= state_n;
            counter          <= counter_n;
            prev             <= prev_n;
            clk_meas_period  <= period_n;
            clk_meas_factor  <= factor_n;
            clk_meas_pow2    <= pow2_n;
            clk_meas_valid   <= valid_n;
            clk_meas_locked  <= locked_n;
            clk_meas_timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_clk_meas.sv
// Directed bench for clk_meas: a 32-bit meter fed by a waveform generator and an 8-bit
// meter driven by hand for saturation.
module tb_clk_meas;
    import clk_meas_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_a = 1'b0;
    logic        in_b = 1'b0;

    logic [31:0] period_a;
    logic [4:0]  factor_a;
    logic        pow2_a, valid_a, locked_a, timeout_a;
    logic [7:0]  period_b;
    logic [4:0]  factor_b;
    logic        pow2_b, valid_b, locked_b, timeout_b;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_gap = 0;
    int t_valid = 0;
    int n = 0;

    // Waveform generator: high for hi cycles, low for lo cycles, phase ph.
    logic gen_en = 1'b0;
    int   hi = 1;
    int   lo = 1;
    int   ph = 0;

    clk_meas #(.CNT_WIDTH(32)) u_a (
        .clk_meas_fsys    (clk),
        .clk_meas_rst     (rst),
        .clk_meas_in      (in_a),
        .clk_meas_period  (period_a),
        .clk_meas_factor  (factor_a),
        .clk_meas_pow2    (pow2_a),
        .clk_meas_valid   (valid_a),
        .clk_meas_locked  (locked_a),
        .clk_meas_timeout (timeout_a)
    );

    clk_meas #(.CNT_WIDTH(8)) u_b (
        .clk_meas_fsys    (clk),
        .clk_meas_rst     (rst),
        .clk_meas_in      (in_b),
        .clk_meas_period  (period_b),
        .clk_meas_factor  (factor_b),
        .clk_meas_pow2    (pow2_b),
        .clk_meas_valid   (valid_b),
        .clk_meas_locked  (locked_b),
        .clk_meas_timeout (timeout_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (gen_en) begin
            in_a = (ph < hi);
            ph   = (ph + 1) % (hi + lo);
        end else begin
            in_a = 1'b0;
        end
    endtask

    task automatic set_wave(input int h, input int l, input int p);
        hi     = h;
        lo     = l;
        ph     = p;
        gen_en = 1'b1;
    endtask

    task automatic do_reset();
        gen_en = 1'b0;
        in_b   = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!valid_a && k < budget);
        last_gap = k;
        if (!valid_a) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: no valid within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        // Reset state of both meters.
        tick();
        tick();
        check("rst_period_a", period_a, 0);
        check("rst_factor_a", factor_a, 0);
        check("rst_pow2_a", pow2_a, 0);
        check("rst_valid_a", valid_a, 0);
        check("rst_locked_a", locked_a, 0);
        check("rst_timeout_a", timeout_a, 0);
        check("rst_state_a", u_a.state, ST_IDLE);
        check("rst_period_b", period_b, 0);
        check("rst_timeout_b", timeout_b, 0);
        rst = 1'b0;

        // Divider factor 4: period 16.
        set_wave(8, 8, 0);
        wait_valid(40, "f4_first");
        check("f4_period", period_a, 16);
        check("f4_factor", factor_a, 4);
        check("f4_pow2", pow2_a, 1);
        check("f4_locked_first", locked_a, 0);
        tick();
        check("f4_valid_pulse", valid_a, 0);
        wait_valid(40, "f4_second");
        check("f4_gap", last_gap + 1, 16);
        check("f4_period2", period_a, 16);
        check("f4_locked", locked_a, 1);

        // Switch to factor 6 ten cycles after the last rise: transient period 42, then 64.
        repeat (6) tick();
        set_wave(32, 32, 32);
        wait_valid(100, "f6_transient");
        check("f6_transient_period", period_a, 42);
        check("f6_transient_locked", locked_a, 0);
        wait_valid(100, "f6_first");
        check("f6_gap", last_gap, 64);
        check("f6_period", period_a, 64);
        check("f6_factor", factor_a, 6);
        check("f6_pow2", pow2_a, 1);
        check("f6_locked_first", locked_a, 0);
        wait_valid(100, "f6_second");
        check("f6_locked", locked_a, 1);

        // Hand waveform 4 high / 6 low: period 10, not a power of two.
        do_reset();
        set_wave(4, 6, 0);
        wait_valid(40, "p10_first");
        check("p10_period", period_a, 10);
        check("p10_pow2", pow2_a, 0);
        check("p10_factor", factor_a, 0);
        check("p10_locked_first", locked_a, 0);
        wait_valid(40, "p10_second");
        check("p10_gap", last_gap, 10);
        check("p10_locked", locked_a, 1);

        // Factor 1: input toggles every cycle.
        do_reset();
        set_wave(1, 1, 0);
        wait_valid(20, "f1_first");
        check("f1_period", period_a, 2);
        check("f1_factor", factor_a, 1);
        check("f1_pow2", pow2_a, 1);
        tick();
        check("f1_valid_gap_low", valid_a, 0);
        tick();
        check("f1_valid_again", valid_a, 1);
        check("f1_locked", locked_a, 1);

        // Factor 3, asynchronous reset mid-period.
        do_reset();
        set_wave(4, 4, 0);
        wait_valid(40, "f3_first");
        wait_valid(40, "f3_second");
        check("f3_locked_pre", locked_a, 1);
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        check("arst_period", period_a, 0);
        check("arst_factor", factor_a, 0);
        check("arst_pow2", pow2_a, 0);
        check("arst_locked", locked_a, 0);
        check("arst_valid", valid_a, 0);
        check("arst_state", u_a.state, ST_IDLE);
        tick();
        tick();
        rst = 1'b0;
        wait_valid(40, "f3_after_reset");
        check("f3_period", period_a, 8);
        check("f3_factor", factor_a, 3);
        check("f3_pow2", pow2_a, 1);
        check("f3_locked_first", locked_a, 0);

        // 8-bit meter: three rises of period 4, then input stops low until saturation.
        gen_en = 1'b0;
        for (int r = 0; r < 3; r++) begin
            in_b = 1'b1;
            tick();
            tick();
            in_b = 1'b0;
            tick();
            if (r > 0) check("w8_valid", valid_b, 1);
            if (r == 2) t_valid = cyc;
            tick();
        end
        check("w8_period", period_b, 4);
        check("w8_factor", factor_b, 2);
        check("w8_locked_pre", locked_b, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!timeout_b && n < 400);
        check("w8_timeout_seen", timeout_b, 1);
        check("w8_timeout_delay", cyc - t_valid, 255);
        check("w8_period_hold", period_b, 4);
        check("w8_factor_hold", factor_b, 2);
        check("w8_pow2_hold", pow2_b, 1);
        check("w8_locked_clear", locked_b, 0);
        check("w8_state_idle", u_b.state, ST_IDLE);
        tick();
        check("w8_timeout_pulse", timeout_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_meas.md
Name: clk_meas

Overview:
Frequency/period meter, the receive-side counterpart of the power-of-two clock divider. Samples a slow divided clock in the system clock domain and counts fsys cycles between consecutive rising edges. Decodes the divider factor when the period is a power of two. Reports lock once two consecutive periods match. Used to check divider settings on the board and to feed measured rates to downstream counter logic.

Parameters:
CNT_WIDTH, 32, width of the period counter and of clk_meas_period; the maximum measurable period is 2^CNT_WIDTH-1 cycles.

Ports:
clk_meas_fsys  input  1  system clock; all logic is on its rising edge.
clk_meas_rst  input  1  asynchronous, active-high reset.
clk_meas_in  input  1  slow clock under measurement (divider output); may be asynchronous to fsys.
clk_meas_period  output  CNT_WIDTH  last measured period in fsys cycles.
clk_meas_factor  output  5  decoded divider factor k where period = 2^k; 0 if the period is not a power of two.
clk_meas_pow2  output  1  last period is 2^k with 1<=k<=31.
clk_meas_valid  output  1  one-cycle pulse when period, factor and pow2 update.
clk_meas_locked  output  1  last two measured periods are equal.
clk_meas_timeout  output  1  one-cycle pulse when no edge arrives before the counter saturates.

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0, the counter is 0, the previous-period register is 0, the synchronizer flops are 0, and the state is IDLE.
- Input path: 3-flop chain s1->s2->s3. rise = s2 & ~s3. The fixed 2-cycle offset cancels in the period.
- Input requirement: high and low phases each >= 1 fsys cycle. Minimum measurable period is 2.
- State IDLE: counter held at 0. On rise: counter <= 1, go to MEAS. No output update on this first edge.
- State MEAS, rise present:
  - clk_meas_period <= counter and clk_meas_valid <= 1.
  - pow2 and factor are decoded combinationally from counter and registered in the same cycle.
  - clk_meas_locked <= (counter == previous period). The previous period is then updated to counter.
  - counter <= 1. Stay in MEAS.
- State MEAS, no rise: counter <= counter+1.
- Timing: for rises detected at cycles t and t+P, clk_meas_period = P from cycle t+P+1. clk_meas_valid is high only in that cycle.
- Factor decode: the counter must have exactly one bit set, at position k with k>=1. Then factor = k and pow2 = 1. Otherwise factor = 0 and pow2 = 0. If CNT_WIDTH > 32, bit positions >31 force pow2 = 0.
- Timeout: in MEAS, if counter == all-ones and no rise this cycle:
  - clk_meas_timeout pulses in the next cycle.
  - State goes to IDLE, locked is cleared, previous period is cleared.
  - period, factor and pow2 hold their last values.
- Simultaneous rise and counter == all-ones: rise wins and this is a normal measurement.
- Reset mid-measurement: the partial count is discarded. The first rise after reset only arms the meter (IDLE->MEAS).
- Wrap-around: the counter never wraps; saturation is always handled as a timeout.
- locked drops in the same cycle valid reports a differing period.

Decomposition:
- Shared package clk_meas_pkg holds:
  - state encoding constants: ST_IDLE = 1'b0, ST_MEAS = 1'b1;
  - SYNC_STAGES = 3;
  - FACTOR_W = 5.
- Sub-module edge_sync contains the synchronizer chain and rise detection. Ports: clock, reset, async input, rise pulse out. The divider-based test benches reuse it.

Test Plan:
1. Drive clk_meas_in from the divider with factor=4 -> after the second rise: period=16, factor=4, pow2=1; valid pulses every 16 cycles; locked=1 from the second valid onward.
2. Hand-driven input, high 4 cycles / low 6 cycles -> period=10, pow2=0, factor=0, locked=1 after the second measurement.
3. Change factor from 4 to 6 mid-run -> one valid with period of 16..64 (transient) and locked=0, then period=64, factor=6; locked=1 on the following valid.
4. CNT_WIDTH=8, input stops low after one rise -> timeout pulses exactly 256 cycles after the rise-detect cycle; state returns to IDLE; period/factor unchanged; locked=0.
5. Assert rst asynchronously mid-period (factor=3) -> all outputs 0 immediately. The first rise after release produces no valid; the next rise gives period=8, factor=3.
6. Factor=1 (input toggles every fsys cycle) -> period=2, factor=1, pow2=1, valid every 2 cycles, locked=1.
